// File: rtl/palette_lookup_arbiter.sv
// Round-robin arbiter that shares one combinational 16-entry palette among
// N_REQ pixel requesters and returns the registered colour one cycle later,
// tagged with the requester ID and a colour-key transparency flag.
module palette_lookup_arbiter #(
  parameter int          N_REQ           = 3,
  parameter logic [3:0]  TRANSPARENT_IDX = 4'h0,
  parameter int          ID_W            = 2
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                stall,
  input  logic [N_REQ-1:0]    req,
  input  logic [4*N_REQ-1:0]  req_idx,
  output logic [N_REQ-1:0]    gnt,
  output logic [3:0]          pal_index,
  input  logic [3:0]          pal_red,
  input  logic [3:0]          pal_green,
  input  logic [3:0]          pal_blue,
  output logic                rsp_valid,
  output logic [ID_W-1:0]     rsp_id,
  output logic [3:0]          rsp_red,
  output logic [3:0]          rsp_green,
  output logic [3:0]          rsp_blue,
  output logic                rsp_transparent
);

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [3:0]      rsp_red_q, rsp_red_d;
  logic [3:0]      rsp_green_q, rsp_green_d;
  logic [3:0]      rsp_blue_q, rsp_blue_d;
  logic            rsp_transparent_q, rsp_transparent_d;

  logic            found;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] sel;
  logic            grant_v;
  logic [ID_W-1:0] winner_next;

  // Round-robin search: first active requester starting at rr_ptr, wrapping at N_REQ.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      int cand;
      cand = int'(rr_ptr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = ID_W'(cand);
      end
    end
  end

  // Grant decode and palette index mux; the index falls back to rr_ptr's requester when idle.
  always_comb begin
    grant_v     = found && !stall;
    sel         = grant_v ? winner : rr_ptr_q;
    pal_index   = req_idx[4*int'(sel) +: 4];
    gnt         = grant_v ? (N_REQ'(1) << winner) : '0;
    winner_next = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
  end

  // Response and pointer next-state: capture on grant, clear valid when idle, hold under stall.
  always_comb begin
    rr_ptr_d          = rr_ptr_q;
    rsp_valid_d       = rsp_valid_q;
    rsp_id_d          = rsp_id_q;
    rsp_red_d         = rsp_red_q;
    rsp_green_d       = rsp_green_q;
    rsp_blue_d        = rsp_blue_q;
    rsp_transparent_d = rsp_transparent_q;
    if (grant_v) begin
      rr_ptr_d          = winner_next;
      rsp_valid_d       = 1'b1;
      rsp_id_d          = winner;
      rsp_red_d         = pal_red;
      rsp_green_d       = pal_green;
      rsp_blue_d        = pal_blue;
      rsp_transparent_d = (pal_index == TRANSPARENT_IDX);
    end else if (!stall) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any in-flight response and restarts the pointer at 0.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ptr_q          <= '0;
      rsp_valid_q       <= 1'b0;
      rsp_id_q          <= '0;
      rsp_red_q         <= '0;
      rsp_green_q       <= '0;
      rsp_blue_q        <= '0;
      rsp_transparent_q <= 1'b0;
    end else begin
      rr_ptr_q          <= rr_ptr_d;
      rsp_valid_q       <= rsp_valid_d;
      rsp_id_q          <= rsp_id_d;
      rsp_red_q         <= rsp_red_d;
      rsp_green_q       <= rsp_green_d;
      rsp_blue_q        <= rsp_blue_d;
      rsp_transparent_q <= rsp_transparent_d;
    end
  end

  assign rsp_valid       = rsp_valid_q;
  assign rsp_id          = rsp_id_q;
  assign rsp_red         = rsp_red_q;
  assign rsp_green       = rsp_green_q;
  assign rsp_blue        = rsp_blue_q;
  assign rsp_transparent = rsp_transparent_q;

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Bench for palette_lookup_arbiter: a small palette ROM, a vector table of
// hand-derived grants, and a response scoreboard fed at each grant.
module tb_palette_lookup_arbiter;

  localparam int N_REQ = 3;
  localparam int ID_W  = 2;

  logic                Clk = 1'b0;
  logic                Reset_n;
  logic                stall;
  logic [N_REQ-1:0]    req;
  logic [4*N_REQ-1:0]  req_idx;
  logic [N_REQ-1:0]    gnt;
  logic [3:0]          pal_index;
  logic [3:0]          pal_red, pal_green, pal_blue;
  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  logic [3:0]          rsp_red, rsp_green, rsp_blue;
  logic                rsp_transparent;

  palette_lookup_arbiter #(.N_REQ(N_REQ), .TRANSPARENT_IDX(4'h0), .ID_W(ID_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .stall(stall), .req(req), .req_idx(req_idx),
    .gnt(gnt), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_red(rsp_red), .rsp_green(rsp_green), .rsp_blue(rsp_blue),
    .rsp_transparent(rsp_transparent)
  );

  always #5 Clk = ~Clk;

  // Combinational palette model.
  logic [11:0] pal_rom [16];
  assign {pal_red, pal_green, pal_blue} = pal_rom[pal_index];

  typedef struct {
    logic [ID_W-1:0] id;
    logic [11:0]     rgb;
    logic            transp;
  } rsp_t;

  typedef struct {
    logic        stall;
    logic [2:0]  req;
    logic [11:0] idx;
    logic [2:0]  gnt;
  } vec_t;

  rsp_t sb_q[$];
  rsp_t last_rsp;
  logic last_valid;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int onehot_id(input logic [2:0] g);
    int r = 0;
    for (int i = 0; i < N_REQ; i++) if (g[i]) r = i;
    return r;
  endfunction

  // Called just after a rising edge; drives one cycle and checks grant then response.
  task automatic apply(input logic s, input logic [2:0] r, input logic [11:0] idx,
                       input logic [2:0] exp_gnt, input string name);
    rsp_t e;
    logic [3:0] widx;
    stall = s; req = r; req_idx = idx;
    #3;
    check({name, " gnt"}, 32'(gnt), 32'(exp_gnt));
    if (exp_gnt != 3'b000) begin
      widx = 4'((idx >> (4 * onehot_id(exp_gnt))) & 12'hF);
      check({name, " pal_index"}, 32'(pal_index), 32'(widx));
      e.id = ID_W'(onehot_id(exp_gnt));
      e.rgb = pal_rom[widx];
      e.transp = (widx == 4'h0);
      sb_q.push_back(e);
    end
    @(posedge Clk);
    #1;
    if (exp_gnt != 3'b000) begin
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL %s scoreboard: got empty queue expected entry", name);
      end else begin
        e = sb_q.pop_front();
        check({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({name, " rsp_id"}, 32'(rsp_id), 32'(e.id));
        check({name, " rsp_rgb"}, 32'({rsp_red, rsp_green, rsp_blue}), 32'(e.rgb));
        check({name, " rsp_transparent"}, 32'(rsp_transparent), 32'(e.transp));
        last_rsp = e;
        last_valid = 1'b1;
      end
    end else if (s) begin
      check({name, " hold valid"}, 32'(rsp_valid), 32'(last_valid));
      check({name, " hold id"}, 32'(rsp_id), 32'(last_rsp.id));
      check({name, " hold rgb"}, 32'({rsp_red, rsp_green, rsp_blue}), 32'(last_rsp.rgb));
      check({name, " hold transparent"}, 32'(rsp_transparent), 32'(last_rsp.transp));
    end else begin
      check({name, " idle valid"}, 32'(rsp_valid), 32'd0);
      last_valid = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) pal_rom[i] = 12'(i * 12'h135 + 12'h20A);
    pal_rom[0] = 12'hEFF;
    pal_rom[1] = 12'h3CE;

    Reset_n = 1'b0; stall = 1'b0; req = '0; req_idx = '0;
    last_rsp.id = '0; last_rsp.rgb = '0; last_rsp.transp = 1'b0; last_valid = 1'b0;
    #12;
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_id", 32'(rsp_id), 32'd0);
    check("reset rsp_rgb", 32'({rsp_red, rsp_green, rsp_blue}), 32'd0);
    check("reset rsp_transparent", 32'(rsp_transparent), 32'd0);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // Round robin over all three, starting from pointer 0.
    tbl.push_back('{1'b0, 3'b111, 12'h731, 3'b001});
    tbl.push_back('{1'b0, 3'b111, 12'h731, 3'b010});
    tbl.push_back('{1'b0, 3'b111, 12'h731, 3'b100});
    // Grant to 0, stall 4 cycles with responses frozen, then 2 then 0.
    tbl.push_back('{1'b0, 3'b101, 12'h731, 3'b001});
    tbl.push_back('{1'b1, 3'b101, 12'h731, 3'b000});
    tbl.push_back('{1'b1, 3'b101, 12'h731, 3'b000});
    tbl.push_back('{1'b1, 3'b101, 12'h731, 3'b000});
    tbl.push_back('{1'b1, 3'b101, 12'h731, 3'b000});
    tbl.push_back('{1'b0, 3'b101, 12'h731, 3'b100});
    tbl.push_back('{1'b0, 3'b101, 12'h731, 3'b001});
    // Single requester with the transparent index, granted every cycle.
    tbl.push_back('{1'b0, 3'b001, 12'h730, 3'b001});
    tbl.push_back('{1'b0, 3'b001, 12'h730, 3'b001});
    tbl.push_back('{1'b0, 3'b001, 12'h730, 3'b001});
    // Requester 1 drops before its turn; 0 and 2 alternate, then an idle cycle.
    tbl.push_back('{1'b0, 3'b101, 12'h5A9, 3'b100});
    tbl.push_back('{1'b0, 3'b111, 12'h5A9, 3'b001});
    tbl.push_back('{1'b0, 3'b101, 12'h5A9, 3'b100});
    tbl.push_back('{1'b0, 3'b101, 12'hC4B, 3'b001});
    tbl.push_back('{1'b0, 3'b000, 12'hC4B, 3'b000});

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i].stall, tbl[i].req, tbl[i].idx, tbl[i].gnt, $sformatf("vec%0d", i));

    // Asynchronous reset mid-cycle after a grant to requester 1 (pointer then at 2).
    apply(1'b0, 3'b111, 12'h731, 3'b010, "pre_reset");
    req = '0;
    #1 Reset_n = 1'b0;
    #1;
    check("async reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("async reset rsp_id", 32'(rsp_id), 32'd0);
    Reset_n = 1'b1;
    last_valid = 1'b0;
    last_rsp.id = '0; last_rsp.rgb = '0; last_rsp.transp = 1'b0;
    @(posedge Clk);
    #1;
    apply(1'b0, 3'b111, 12'h731, 3'b001, "post_reset");

    // Pointer now 1: only req[2] wins, pointer wraps to 0, so 0 beats 2 next.
    apply(1'b0, 3'b100, 12'h731, 3'b100, "wrap_a");
    apply(1'b0, 3'b101, 12'h731, 3'b001, "wrap_b");
    apply(1'b0, 3'b100, 12'hF31, 3'b100, "wrap_c");
    apply(1'b0, 3'b100, 12'hF31, 3'b100, "wrap_d");
    apply(1'b0, 3'b000, 12'hF31, 3'b000, "final_idle");

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d entries expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
